jbcont_pred: RTL and testbench

Parametrised jump/branch control with dynamic branch prediction for the pipelined datapath. It supports the same jump/branch op set as the single-cycle jump/branch control. It keeps a pattern history table (PHT) of 2-bit saturating counters that is read at fetch and trained at execute. At execute it resolves each branch from `zout`/`nout`, drives `pcsrc`, `jspal` and `balrzwrite`, and raises `flush` on a redirect or mispredict. Saturating statistics counters support performance measurement.

---
 rtl/jb_pkg.sv | 38 +++
 rtl/jbcont_pred_pht.sv | 37 +++
 rtl/jbcont_pred.sv | 116 +++++++++++
 tb/tb_jbcont_pred.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jb_pkg.sv
// Shared definitions for the jump/branch control: op encodings, PC-mux
// select encodings and the 2-bit saturating prediction counter.
package jb_pkg;

  // Jump/branch op, encoded {bj2,bj1,bj0}
  typedef enum logic [2:0] {
    BJ_NONE  = 3'b000,
    BJ_BEQZ  = 3'b001,
    BJ_BNEZ  = 3'b010,
    BJ_JSPAL = 3'b011,
    BJ_BALRZ = 3'b100,
    BJ_BLTZ  = 3'b101,
    BJ_BGEZ  = 3'b110,
    BJ_J     = 3'b111
  } bj_op_e;

  // PC mux select encodings
  localparam logic [1:0] PC_SEQ = 2'b00;  // ex_pc + 4
  localparam logic [1:0] PC_REL = 2'b01;  // PC-relative target
  localparam logic [1:0] PC_ABS = 2'b10;  // absolute jump target
  localparam logic [1:0] PC_REG = 2'b11;  // register target

  // 2-bit saturating prediction counter; MSB is the taken prediction
  typedef logic [1:0] ctr_t;

  // One training step: count up on taken, down on not-taken, clamp at 11/00
  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != 2'b11) n = c + 2'b01;
    end else begin
      if (c != 2'b00) n = c - 2'b01;
    end
    return n;
  endfunction

endpackage

// File: rtl/jbcont_pred_pht.sv
// Pattern history table: DEPTH x 2-bit counters, one combinational read
// port for fetch and one training write port for execute. The write port
// takes the resolved direction and applies the saturating step internally,
// so the read port always returns the pre-update value (no bypass).
module pht
  import jb_pkg::*;
#(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] raddr,
  output logic [1:0]       rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             wtaken
);

  localparam int DEPTH = 1 << IDX_W;

  ctr_t mem [DEPTH];

  assign rdata = mem[raddr];

  // Reset every entry to INIT_CTR; otherwise train the addressed counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_CTR;
      end
    end else if (we) begin
      mem[waddr] <= ctr_step(mem[waddr], wtaken);
    end
  end

endmodule

// File: rtl/jbcont_pred.sv
// Jump/branch control with 2-bit dynamic prediction for the pipelined
// datapath. Fetch reads a prediction from the PHT; execute resolves the
// op from zout/nout, drives the PC mux, link writes and flush, and trains
// the PHT plus the saturating statistics counters.
//
// Qualification: the execute inputs are acted on only when ex_valid=1 and
// ex_stall=0 ("act"). A stalled instruction keeps its inputs stable and is
// resolved in its first unstalled cycle; all outputs are 0 while act=0.
module jbcont_pred
  import jb_pkg::*;
#(
  parameter int         IDX_W    = 4,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [31:0]      ex_pc,
  input  logic [2:0]       ex_bj,
  input  logic             ex_pred_taken,
  input  logic             zout,
  input  logic             nout,
  output logic [1:0]       pcsrc,
  output logic             flush,
  output logic             jspal,
  output logic             balrzwrite,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bj_op_e     op;
  logic       act;
  logic       is_pred;   // conditional branch that uses/trains the PHT
  logic       taken;
  logic       upd;
  logic [1:0] f_ctr;

  assign op  = bj_op_e'(ex_bj);
  assign act = ex_valid & ~ex_stall;
  assign upd = act & is_pred;

  // Resolve the execute-stage op into taken, flush and the PC mux select
  always_comb begin
    is_pred    = 1'b0;
    taken      = 1'b0;
    flush      = 1'b0;
    pcsrc      = PC_SEQ;
    jspal      = 1'b0;
    balrzwrite = 1'b0;
    if (act) begin
      unique case (op)
        BJ_BEQZ: begin is_pred = 1'b1; taken = zout;  end
        BJ_BNEZ: begin is_pred = 1'b1; taken = ~zout; end
        BJ_BLTZ: begin is_pred = 1'b1; taken = nout;  end
        BJ_BGEZ: begin is_pred = 1'b1; taken = ~nout; end
        BJ_JSPAL: begin
          taken = 1'b1;
          jspal = 1'b1;
          flush = 1'b1;
          pcsrc = PC_REG;
        end
        BJ_BALRZ: begin
          taken      = zout;
          balrzwrite = zout;
          flush      = zout;
          pcsrc      = zout ? PC_REG : PC_SEQ;
        end
        BJ_J: begin
          taken = 1'b1;
          flush = 1'b1;
          pcsrc = PC_ABS;
        end
        default: begin end  // BJ_NONE
      endcase
      // Predicted branches redirect only when the guess was wrong
      if (is_pred) begin
        flush = (taken != ex_pred_taken);
        pcsrc = taken ? PC_REL : PC_SEQ;
      end
    end
  end

  pht #(
    .IDX_W    (IDX_W),
    .INIT_CTR (INIT_CTR)
  ) u_pht (
    .clk    (clk),
    .reset  (reset),
    .raddr  (f_pc[IDX_W+1:2]),
    .rdata  (f_ctr),
    .we     (upd),
    .waddr  (ex_pc[IDX_W+1:2]),
    .wtaken (taken)
  );

  assign f_pred_taken = f_ctr[1];

  // Count resolved and mispredicted conditional branches, holding at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (upd) begin
      if (br_count != CNT_MAX) br_count <= br_count + CNT_ONE;
      if (flush && (mp_count != CNT_MAX)) mp_count <= mp_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_jbcont_pred.sv
// Directed bench for jbcont_pred: a table of single-cycle resolve vectors,
// then hand-written sequences for training, redirects, stall, same-index
// collision and counter saturation (second instance with CNT_W=2).
module tb_jbcont_pred;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] f_pc;
  logic        ex_valid, ex_stall;
  logic [31:0] ex_pc;
  logic [2:0]  ex_bj;
  logic        ex_pred_taken, zout, nout;

  logic        f_pred_taken, flush, jspal, balrzwrite;
  logic [1:0]  pcsrc;
  logic [15:0] br_count, mp_count;

  logic        f_pred_s, flush_s, jspal_s, balrz_s;
  logic [1:0]  pcsrc_s;
  logic [1:0]  br_s, mp_s;

  jbcont_pred dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_bj(ex_bj),
    .ex_pred_taken(ex_pred_taken), .zout(zout), .nout(nout),
    .pcsrc(pcsrc), .flush(flush), .jspal(jspal), .balrzwrite(balrzwrite),
    .br_count(br_count), .mp_count(mp_count)
  );

  jbcont_pred #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_s),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_bj(ex_bj),
    .ex_pred_taken(ex_pred_taken), .zout(zout), .nout(nout),
    .pcsrc(pcsrc_s), .flush(flush_s), .jspal(jspal_s), .balrzwrite(balrz_s),
    .br_count(br_s), .mp_count(mp_s)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Move to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_stall = 1'b0; ex_bj = 3'b000;
    ex_pred_taken = 1'b0; zout = 1'b0; nout = 1'b0;
  endtask

  task automatic drive(input logic [2:0] bj, input logic [31:0] pc, input logic pred,
                       input logic z, input logic n, input logic stall);
    ex_valid = 1'b1; ex_stall = stall; ex_bj = bj; ex_pc = pc;
    ex_pred_taken = pred; zout = z; nout = n;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
    f_pc = pc;
    #1;
    chk(name, {31'd0, f_pred_taken}, {31'd0, exp});
  endtask

  task automatic chk_out(input string name, input logic fl, input logic [1:0] ps,
                         input logic js, input logic bw);
    chk({name, ".flush"}, {31'd0, flush}, {31'd0, fl});
    chk({name, ".pcsrc"}, {30'd0, pcsrc}, {30'd0, ps});
    chk({name, ".jspal"}, {31'd0, jspal}, {31'd0, js});
    chk({name, ".balrz"}, {31'd0, balrzwrite}, {31'd0, bw});
  endtask

  task automatic chk_cnt(input string name, input int br, input int mp);
    chk({name, ".br"}, {16'd0, br_count}, br);
    chk({name, ".mp"}, {16'd0, mp_count}, mp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       valid, stall;
    logic [2:0] bj;
    logic       pred, z, n;
    logic       e_flush;
    logic [1:0] e_pcsrc;
    logic       e_jspal, e_balrz;
  } vec_t;

  vec_t vt [14];
  int   exp_br, exp_mp;

  initial begin
    reset = 1'b1; f_pc = '0; ex_pc = '0;
    idle();
    tick();
    reset = 1'b0;

    //         valid stall bj      pred z     n     flush pcsrc  jspal balrz
    vt[0]  = '{1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 3'b110, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};

    // ---- reset: all predictions not-taken, counters clear ----
    for (int i = 0; i < 16; i++) chk_pred($sformatf("rst.pred%0d", i), i * 4, 1'b0);
    chk_cnt("rst", 0, 0);

    // ---- table: single-cycle resolve at ex_pc=0x24 (index 9) ----
    exp_br = 0; exp_mp = 0;
    for (int i = 0; i < 14; i++) begin
      ex_valid = vt[i].valid; ex_stall = vt[i].stall; ex_bj = vt[i].bj;
      ex_pc = 32'h24; ex_pred_taken = vt[i].pred; zout = vt[i].z; nout = vt[i].n;
      #1;
      chk_out($sformatf("vec%0d", i), vt[i].e_flush, vt[i].e_pcsrc, vt[i].e_jspal, vt[i].e_balrz);
      if (i >= 3 && i <= 9) begin
        exp_br++;
        if (vt[i].e_flush) exp_mp++;
      end
      tick();
    end
    idle();
    chk_cnt("table", exp_br, exp_mp);           // 7 / 4
    chk_pred("table.pred_idx9", 32'h24, 1'b1); // 01 t10 n01 n00 t01 t10 n01 t10

    // ---- training at 0x40 (index 0) ----
    do_reset();
    drive(3'b001, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("train1", 1'b1, 2'b01, 1'b0, 1'b0);
    tick(); idle();
    chk_cnt("train1", 1, 1);
    chk_pred("train1.pred", 32'h40, 1'b1);      // 01 -> 10
    for (int k = 0; k < 3; k++) begin
      drive(3'b001, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
    chk_cnt("train4", 4, 4);
    chk_pred("train4.pred", 32'h40, 1'b1);      // saturated at 11
    drive(3'b010, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("bnez_nt", 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); idle();
    chk_pred("sat.ctr10", 32'h40, 1'b1);        // 11 -> 10
    drive(3'b010, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    chk_pred("sat.ctr01", 32'h40, 1'b0);        // 10 -> 01 (no wrap earlier)
    chk_cnt("bnez", 6, 6);

    // ---- redirects: no PHT or counter activity ----
    drive(3'b011, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("jspal", 1'b1, 2'b11, 1'b1, 1'b0);
    tick();
    drive(3'b100, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("balrz_nt", 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(3'b100, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("balrz_t", 1'b1, 2'b11, 1'b0, 1'b1);
    tick();
    drive(3'b111, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("j", 1'b1, 2'b10, 1'b0, 1'b0);
    tick(); idle();
    chk_cnt("redir", 6, 6);
    chk_pred("redir.pred", 32'h40, 1'b0);

    // ---- stall: bltz at 0x44 (index 1) held for 3 cycles ----
    for (int k = 0; k < 3; k++) begin
      drive(3'b101, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_out($sformatf("stall%0d", k), 1'b0, 2'b00, 1'b0, 1'b0);
      tick();
      chk_cnt($sformatf("stall%0d", k), 6, 6);
      chk_pred($sformatf("stall%0d.pred", k), 32'h44, 1'b0);
    end
    drive(3'b101, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("release", 1'b1, 2'b01, 1'b0, 1'b0);
    tick(); idle();
    chk_cnt("release", 7, 7);
    chk_pred("release.pred", 32'h44, 1'b1);

    // ---- same-index collision at 0x80: no bypass ----
    do_reset();
    f_pc = 32'h80;
    drive(3'b001, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("coll.same", {31'd0, f_pred_taken}, 32'd0);
    tick(); idle();
    #1;
    chk("coll.next", {31'd0, f_pred_taken}, 32'd1);

    // ---- saturation on the CNT_W=2 instance ----
    do_reset();
    for (int k = 1; k <= 5; k++) exp_q.push_back((k > 3) ? 32'd3 : k);
    for (int k = 1; k <= 5; k++) begin
      drive(3'b001, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      exp_br = exp_q.pop_front();
      chk($sformatf("sat%0d.br", k), {30'd0, br_s}, exp_br);
      chk($sformatf("sat%0d.mp", k), {30'd0, mp_s}, exp_br);
    end
    idle();
    tick();
    chk("sat.hold.br", {30'd0, br_s}, 32'd3);
    chk("sat.hold.mp", {30'd0, mp_s}, 32'd3);

    // ---- reset mid-sequence with a branch in execute ----
    do_reset();
    f_pc = 32'h90;
    drive(3'b001, 32'h90, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mid.br_pre", {30'd0, br_s}, 32'd1);
    drive(3'b001, 32'h90, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; idle();
    #1;
    chk("mid.br_s", {30'd0, br_s}, 32'd0);
    chk("mid.mp_s", {30'd0, mp_s}, 32'd0);
    chk_cnt("mid", 0, 0);
    chk("mid.pred", {31'd0, f_pred_taken}, 32'd0);  // training discarded

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
